// File: rtl/fft_pkg.sv
// Shared constants, Q1.7 twiddle tables and FSM encoding for the FFT twiddle sequencer.
package fft_pkg;

  localparam int DEF_N_LOG2 = 4;
  localparam int DEF_COEF_W = 8;

  localparam logic [7:0] Q_POS_ONE = 8'h7F;
  localparam logic [7:0] Q_NEG_ONE = 8'h81;

  localparam logic [7:0] COS16 [8] = '{Q_POS_ONE, 8'h76, 8'h5B, 8'h31,
                                       8'h00, 8'hCF, 8'hA5, 8'h8A};
  localparam logic [7:0] NSIN16 [8] = '{8'h00, 8'hCF, 8'hA5, 8'h8A,
                                        Q_NEG_ONE, 8'h8A, 8'hA5, 8'hCF};

  // Quarter wave of cos(2*pi*m/64), m=0..16, for transforms of 32 and 64 points
  localparam logic [7:0] QCOS64 [17] = '{8'd127, 8'd127, 8'd126, 8'd122, 8'd118, 8'd113,
                                         8'd106, 8'd99, 8'd91, 8'd81, 8'd71, 8'd60,
                                         8'd49, 8'd37, 8'd25, 8'd13, 8'd0};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fsm_state_t;

  // Returns {cos, -sin} for angle 2*pi*m/64 by quadrant folding of QCOS64.
  function automatic logic [15:0] twiddle64(input logic [5:0] m);
    logic [4:0] a, b;
    logic [7:0] c, s, re, sn;
    a = {1'b0, m[3:0]};
    b = 5'd16 - a;
    c = QCOS64[a];
    s = QCOS64[b];
    unique case (m[5:4])
      2'd0:    begin re = c;        sn = s;        end
      2'd1:    begin re = 8'(-s);   sn = c;        end
      2'd2:    begin re = 8'(-c);   sn = 8'(-s);   end
      default: begin re = s;        sn = 8'(-c);   end
    endcase
    return {re, 8'(-sn)};
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: exponent k of an N-point transform to {cos, -sin} in Q1.7.
module fft_twiddle_rom import fft_pkg::*; #(
  parameter int N_LOG2 = DEF_N_LOG2
) (
  input  logic [N_LOG2-2:0] k,
  output logic [7:0]        re,
  output logic [7:0]        im
);

  generate
    if (N_LOG2 <= 4) begin : g_tab16
      logic [2:0] idx;
      // Smaller transforms use every 2nd or 4th entry of the 16-point table
      always_comb begin
        idx = 3'(k) << (4 - N_LOG2);
        re  = COS16[idx];
        im  = NSIN16[idx];
      end
    end else begin : g_tab64
      logic [5:0] m;
      always_comb begin
        m        = 6'(k) << (6 - N_LOG2);
        {re, im} = twiddle64(m);
      end
    end
  endgenerate

endmodule

// File: rtl/fft_twiddle_seq.sv
// Twiddle-factor sequencer feeding the 17x8 multiplier of the radix-2 DIF FFT.
// Define TWIDDLE_CONJ_EN to add the 'inverse' input that conjugates coefficients for the IFFT.
module fft_twiddle_seq import fft_pkg::*; #(
  parameter int N_LOG2   = DEF_N_LOG2,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int MULT_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      en,
`ifdef TWIDDLE_CONJ_EN
  input  logic                      inverse,
`endif
  output logic                      busy,
  output logic [COEF_W-1:0]         tw_re,
  output logic [COEF_W-1:0]         tw_im,
  output logic                      tw_valid,
  output logic [$clog2(N_LOG2)-1:0] tw_stage,
  output logic [N_LOG2-2:0]         tw_bfly,
  output logic                      tw_last,
  output logic                      prod_valid,
  output logic                      prod_last,
  output logic                      done
);

  localparam int SW = $clog2(N_LOG2);
  localparam int KW = N_LOG2 - 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);

  fsm_state_t          state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [KW-1:0]       j_q, j_d, k;
  logic [COEF_W-1:0]   tw_re_q, tw_re_d, tw_im_q, tw_im_d;
  logic [SW-1:0]       tw_stage_q, tw_stage_d;
  logic [KW-1:0]       tw_bfly_q, tw_bfly_d;
  logic                tw_valid_q, tw_valid_d, tw_last_q, tw_last_d;
  logic [MULT_LAT-1:0] dly_valid_q, dly_valid_d, dly_last_q, dly_last_d;
  logic [7:0]          rom_re, rom_im;
  logic                accept, issue, last_coef, conj;

  // Counters are zero whenever idle, so the first coefficient comes straight from them
  assign k         = j_q << stage_q;
  assign accept    = (state_q == IDLE) && start;
  assign issue     = en && ((state_q == RUN) || accept);
  assign last_coef = (stage_q == LAST_STAGE) && (j_q == '1);

  fft_twiddle_rom #(.N_LOG2(N_LOG2)) u_rom (
    .k  (k),
    .re (rom_re),
    .im (rom_im)
  );

`ifdef TWIDDLE_CONJ_EN
  logic inv_q, inv_d;

  assign conj = accept ? inverse : inv_q;

  always_comb begin
    inv_d = accept ? inverse : inv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_d;
  end
`else
  assign conj = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    j_d         = j_q;
    tw_re_d     = tw_re_q;
    tw_im_d     = tw_im_q;
    tw_stage_d  = tw_stage_q;
    tw_bfly_d   = tw_bfly_q;
    tw_valid_d  = 1'b0;
    tw_last_d   = 1'b0;
    // The multiplier never stalls, so its tag pipeline shifts regardless of en
    dly_valid_d = MULT_LAT'({dly_valid_q, tw_valid_q});
    dly_last_d  = MULT_LAT'({dly_last_q, tw_last_q});

    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     state_d = state_q;
      FLUSH:   if (dly_last_q[MULT_LAT-1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      tw_valid_d = 1'b1;
      tw_last_d  = last_coef;
      tw_re_d    = COEF_W'($signed(rom_re));
      tw_im_d    = conj ? COEF_W'(-$signed(rom_im)) : COEF_W'($signed(rom_im));
      tw_stage_d = stage_q;
      tw_bfly_d  = j_q;
      j_d        = j_q + 1'b1;
      if (j_q == '1) stage_d = stage_q + 1'b1;
      if (last_coef) begin
        state_d = FLUSH;
        stage_d = '0;
        j_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      tw_re_q     <= '0;
      tw_im_q     <= '0;
      tw_stage_q  <= '0;
      tw_bfly_q   <= '0;
      tw_valid_q  <= 1'b0;
      tw_last_q   <= 1'b0;
      dly_valid_q <= '0;
      dly_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      j_q         <= j_d;
      tw_re_q     <= tw_re_d;
      tw_im_q     <= tw_im_d;
      tw_stage_q  <= tw_stage_d;
      tw_bfly_q   <= tw_bfly_d;
      tw_valid_q  <= tw_valid_d;
      tw_last_q   <= tw_last_d;
      dly_valid_q <= dly_valid_d;
      dly_last_q  <= dly_last_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign tw_re      = tw_re_q;
  assign tw_im      = tw_im_q;
  assign tw_valid   = tw_valid_q;
  assign tw_stage   = tw_stage_q;
  assign tw_bfly    = tw_bfly_q;
  assign tw_last    = tw_last_q;
  assign prod_valid = dly_valid_q[MULT_LAT-1];
  assign prod_last  = dly_last_q[MULT_LAT-1];
  assign done       = (state_q == FLUSH) && dly_last_q[MULT_LAT-1];

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Bench for fft_twiddle_seq (N=16, MULT_LAT=4): transform-level model checked every cycle,
// directed pins on tables, stall, busy-start and abort, then randomized start/en/rst traffic.
module tb_fft_twiddle_seq;

  logic       clk = 1'b0;
  logic       rst, start, en, inverse;
  logic       busy, tw_valid, tw_last, prod_valid, prod_last, done;
  logic [7:0] tw_re, tw_im;
  logic [1:0] tw_stage;
  logic [2:0] tw_bfly;

  fft_twiddle_seq #(.N_LOG2(4), .COEF_W(8), .MULT_LAT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .en         (en),
`ifdef TWIDDLE_CONJ_EN
    .inverse    (inverse),
`endif
    .busy       (busy),
    .tw_re      (tw_re),
    .tw_im      (tw_im),
    .tw_valid   (tw_valid),
    .tw_stage   (tw_stage),
    .tw_bfly    (tw_bfly),
    .tw_last    (tw_last),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  logic [7:0] cos_tab  [8] = '{8'h7F, 8'h76, 8'h5B, 8'h31, 8'h00, 8'hCF, 8'hA5, 8'h8A};
  logic [7:0] nsin_tab [8] = '{8'h00, 8'hCF, 8'hA5, 8'h8A, 8'h81, 8'h8A, 8'hA5, 8'hCF};

  // Model: phase 0=idle 1=issuing 2=draining; m_n counts coefficients issued so far
  int         m_phase = 0;
  int         m_n     = 0;
  bit         m_inv   = 0;
  bit         model_live = 0;
  logic [7:0] e_re = 0, e_im = 0;
  logic [1:0] e_stage = 0;
  logic [2:0] e_bfly = 0;
  bit         e_valid = 0, e_last = 0, e_pv = 0, e_pl = 0, e_done = 0, e_busy = 0;
  bit         vhist[$];
  bit         lhist[$];

  int         cyc = 0;
  int         last_cyc = 0, done_cyc = 0;
  bit         cap_on = 0;
  logic [7:0] cap_re[$];
  logic [7:0] cap_im[$];

  always @(posedge clk) begin
    int st, jj, kk;
    bit issue;
    cyc++;
    if (rst) begin
      model_live = 1;
      m_phase = 0; m_n = 0; m_inv = 0;
      e_re = 0; e_im = 0; e_stage = 0; e_bfly = 0;
      e_valid = 0; e_last = 0; e_pv = 0; e_pl = 0; e_done = 0;
      vhist = '{0, 0, 0, 0, 0};
      lhist = '{0, 0, 0, 0, 0};
    end else if (model_live) begin
      issue   = 0;
      e_valid = 0;
      e_last  = 0;
      if (m_phase == 0 && start) begin
        m_phase = 1;
        m_n     = 0;
`ifdef TWIDDLE_CONJ_EN
        m_inv   = inverse;
`else
        m_inv   = 0;
`endif
        issue   = en;
      end else if (m_phase == 1) begin
        issue = en;
      end else if (m_phase == 2 && e_done) begin
        m_phase = 0;
      end
      if (issue) begin
        st      = m_n / 8;
        jj      = m_n % 8;
        kk      = (jj << st) % 8;
        e_valid = 1;
        e_stage = 2'(st);
        e_bfly  = 3'(jj);
        e_re    = cos_tab[kk];
        e_im    = m_inv ? 8'(-nsin_tab[kk]) : nsin_tab[kk];
        e_last  = (m_n == 31);
        m_n++;
        if (m_n == 32) m_phase = 2;
      end
      // Products are the coefficient tags of exactly four cycles earlier
      vhist.push_back(e_valid);
      lhist.push_back(e_last);
      while (vhist.size() > 5) void'(vhist.pop_front());
      while (lhist.size() > 5) void'(lhist.pop_front());
      e_pv   = vhist[0];
      e_pl   = lhist[0];
      e_done = e_pl;
    end
    e_busy = (m_phase != 0);
    #1;
    if (model_live) begin
      check_output("busy",       busy,       e_busy);
      check_output("tw_valid",   tw_valid,   e_valid);
      check_output("tw_last",    tw_last,    e_last);
      check_output("tw_re",      tw_re,      e_re);
      check_output("tw_im",      tw_im,      e_im);
      check_output("tw_stage",   tw_stage,   e_stage);
      check_output("tw_bfly",    tw_bfly,    e_bfly);
      check_output("prod_valid", prod_valid, e_pv);
      check_output("prod_last",  prod_last,  e_pl);
      check_output("done",       done,       e_done);
      if (cap_on && tw_valid === 1'b1) begin
        cap_re.push_back(tw_re);
        cap_im.push_back(tw_im);
      end
      if (tw_last === 1'b1) last_cyc = cyc;
      if (done === 1'b1) done_cyc = cyc;
    end
  end

  task automatic apply_stimulus(input bit r, input bit s, input bit e);
    rst   = r;
    start = s;
    en    = e;
    @(negedge clk);
  endtask

  initial begin
    int guard, bad_seen;
    logic [7:0] s0_re [8];
    logic [7:0] s1_re [8];
    s0_re = '{8'h7F, 8'h76, 8'h5B, 8'h31, 8'h00, 8'hCF, 8'hA5, 8'h8A};
    s1_re = '{8'h7F, 8'h5B, 8'h00, 8'hA5, 8'h7F, 8'h5B, 8'h00, 8'hA5};

    rst = 1; start = 1; en = 1; inverse = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy",  busy,       0);
    check_output("rst_valid", tw_valid,   0);
    check_output("rst_re",    tw_re,      0);
    check_output("rst_prod",  prod_valid, 0);
    check_output("rst_done",  done,       0);
    rst = 0; start = 0;
    repeat (4) @(negedge clk);
    check_output("idle_no_valid", tw_valid, 0);

    // Full transform with en held high
    cap_re.delete();
    cap_im.delete();
    cap_on = 1;
    apply_stimulus(0, 1, 1);
    start = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    check_output("run1_done_seen", done, 1);
    cap_on = 0;
    check_output("run1_count", cap_re.size(), 32);
    if (cap_re.size() == 32) begin
      for (int i = 0; i < 8; i++) check_output("stage0_re", cap_re[i], s0_re[i]);
      for (int i = 0; i < 8; i++) check_output("stage1_re", cap_re[8+i], s1_re[i]);
      for (int i = 24; i < 32; i++) begin
        check_output("stage3_re", cap_re[i], 8'h7F);
        check_output("stage3_im", cap_im[i], 8'h00);
      end
    end
    check_output("last_to_done", done_cyc - last_cyc, 4);
    check_output("busy_in_done", busy, 1);
    @(negedge clk);
    check_output("busy_after_done", busy, 0);

    // Restart in the cycle after done
    apply_stimulus(0, 1, 1);
    start = 0;
    check_output("restart_valid", tw_valid, 1);
    check_output("restart_busy",  busy,     1);
    check_output("restart_re",    tw_re,    8'h7F);

    // Stall at stage 1, j=2
    guard = 0;
    while (!(tw_valid === 1'b1 && tw_stage === 2'd1 && tw_bfly === 3'd2) && guard < 100) begin
      @(negedge clk); guard++;
    end
    check_output("stall_reached", tw_bfly, 3'd2);
    en = 0;
    repeat (3) begin
      @(negedge clk);
      check_output("stall_valid", tw_valid, 0);
      check_output("stall_re",    tw_re,    8'h00);
      check_output("stall_im",    tw_im,    8'h81);
      check_output("stall_bfly",  tw_bfly,  3'd2);
    end
    apply_stimulus(0, 0, 1);
    check_output("resume_valid", tw_valid, 1);
    check_output("resume_bfly",  tw_bfly,  3'd3);
    check_output("resume_re",    tw_re,    8'hA5);
    check_output("resume_im",    tw_im,    8'hA5);

    // start while busy must not disturb the counters
    apply_stimulus(0, 1, 1);
    start = 0;
    check_output("busy_start_stage", tw_stage, 2'd1);
    check_output("busy_start_bfly",  tw_bfly,  3'd4);

    // Abort with reset at stage 2
    guard = 0;
    while (!(tw_valid === 1'b1 && tw_stage === 2'd2) && guard < 100) begin
      @(negedge clk); guard++;
    end
    check_output("abort_reached", tw_stage, 2'd2);
    apply_stimulus(1, 0, 1);
    rst = 0;
    check_output("abort_busy",  busy,       0);
    check_output("abort_valid", tw_valid,   0);
    check_output("abort_re",    tw_re,      0);
    check_output("abort_prod",  prod_valid, 0);
    bad_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (prod_valid === 1'b1 || done === 1'b1) bad_seen++;
    end
    check_output("abort_no_prod", bad_seen, 0);

    // Randomized traffic
    repeat (3000) begin
      inverse = 1'($urandom_range(0, 1));
      apply_stimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 3) != 0));
    end
    apply_stimulus(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
